operand_fetch: RTL and testbench
================================

# operand_fetch

Register-read and operand-staging stage directly upstream of the MiniMIPS ALU. Holds the 32 x 32-bit general-purpose register file. Reads rs/rt with write-back bypass and builds the second operand from either rt or an extended 16-bit immediate. Delivers registered A/B operand words to the ALU over a valid/ready handshake; the ALU's bitwise, add and compare units consume them directly.

## Interface
- DATA_W, 32, operand and register width
- NUM_REGS, 32, register count (address width 5)
- IMM_W, 16, immediate field width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction's operand request
- in_ready  out  1  stage can accept this cycle
- rs  in  5  source register index for A
- rt  in  5  source register index for B
- imm  in  16  immediate field
- use_imm  in  1  1: B = extended imm; 0: B = reg[rt]
- sign_ext  in  1  1: sign-extend imm; 0: zero-extend
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back index
- wb_data  in  32  write-back value
- out_valid  out  1  alu_a/alu_b hold a valid operand pair
- out_ready  in  1  ALU consumes this cycle
- alu_a  out  32  operand A
- alu_b  out  32  operand B

## Operation
- Register file: on rising clk with wb_en=1 and wb_addr≠0, reg[wb_addr] ← wb_data. Write-back is independent of the handshake. Writes to r0 are dropped. r0 always reads 0.
- Read bypass: read_x = 0 if idx=0; else wb_data if wb_en and wb_addr=idx; else reg[idx].
- Immediate: ext = sign_ext ? {16{imm[15]}, imm} : {16'h0000, imm}.
- Operand B source: use_imm ? ext : read_rt.
- Output stage is a single-entry register:
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready: alu_a ← read_rs, alu_b ← B source, out_valid ← 1. Also latch rs, rt and use_imm into held_rs, held_rt and held_imm.
  - Drain with no accept (out_valid & out_ready & !accept): out_valid ← 0. alu_a and alu_b keep their last values.
  - Simultaneous drain and accept: the new pair replaces the old one and out_valid stays 1.
- Hold refresh: while out_valid=1 and no accept occurs, any write-back with wb_en and wb_addr≠0 updates the held operands.
  - If wb_addr=held_rs, alu_a ← wb_data.
  - If held_imm=0 and wb_addr=held_rt, alu_b ← wb_data.
  - Both update if both indices match.
  - Result: a stalled pair never goes stale.
- Reset (asynchronous, any time, including mid-stall): all registers, alu_a, alu_b, held fields ← 0, and out_valid ← 0. A pending pair is discarded.

## Timing
- Latency: accept at edge N → out_valid=1 with the operands during cycle N+1.
- Throughput: 1 pair/cycle while out_ready=1.
- A write-back at edge N is visible to a read accepted at edge N through the bypass, and to later reads through the register file.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Outputs after reset release: out_valid=0, in_ready=1, alu_a=alu_b=0.

## Structure
- Shared package minimips_pkg: DATA_W, NUM_REGS, REG_ADDR_W=5, IMM_W, and the ZERO_REG=5'd0 constant.
- Sub-module reg_file_32x32: storage, async-reset clear, r0 hardwiring, two combinational read ports, one write port.
- Bypass, immediate extension, handshake and hold refresh live in operand_fetch.

## Test plan
- Reset: assert rst_n=0 mid-transfer → out_valid=0 and alu_a=alu_b=0 immediately; after release, rs=9 reads 0.
- Basic read: write r5=0xDEADBEEF; then accept rs=5, rt=0, use_imm=0 → next cycle out_valid=1, alu_a=0xDEADBEEF, alu_b=0.
- Bypass: in the same cycle, wb r7=0x12345678 and accept rs=7, rt=7 → alu_a=alu_b=0x12345678. A wb to r0 of 0xFFFFFFFF with rs=0 → alu_a=0.
- Immediate: imm=0x8001, sign_ext=1 → alu_b=0xFFFF8001. With sign_ext=0 → alu_b=0x00008001. reg[rt] is ignored.
- Stall and refresh: hold out_ready=0 with held rs=3, rt=4. Then wb r3=0x55 → alu_a=0x55 next cycle, alu_b unchanged, in_ready=0, and a new in_valid is not accepted.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with rs=1..4 → four consecutive pairs, no bubbles, out_valid continuously 1.

Source files
------------

// File: rtl/minimips_pkg.sv
// Shared MiniMIPS widths, register-index constants and immediate extension helper.
package minimips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned IMM_W      = 16;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [IMM_W-1:0]      imm_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

    function automatic word_t ext_imm(input imm_t imm, input logic sign_ext);
        if (sign_ext)
            return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        else
            return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Handshake bundles: decode-side operand request and ALU-side operand delivery.
interface of_req_if;
    import minimips_pkg::*;

    logic     in_valid;
    logic     in_ready;
    reg_idx_t rs;
    reg_idx_t rt;
    imm_t     imm;
    logic     use_imm;
    logic     sign_ext;

    modport master (output in_valid, rs, rt, imm, use_imm, sign_ext, input in_ready);
    modport slave  (input in_valid, rs, rt, imm, use_imm, sign_ext, output in_ready);
endinterface

interface of_alu_if;
    import minimips_pkg::*;

    logic  out_valid;
    logic  out_ready;
    word_t alu_a;
    word_t alu_b;

    modport master (output out_valid, alu_a, alu_b, input out_ready);
    modport slave  (input out_valid, alu_a, alu_b, output out_ready);
endinterface

// File: rtl/operand_fetch_regfile.sv
// 32 x 32-bit register file: one write port, two combinational read ports, r0 hardwired to zero.
module reg_file_32x32
    import minimips_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_we,
    input  reg_idx_t i_waddr,
    input  word_t    i_wdata,
    input  reg_idx_t i_raddr_a,
    output word_t    o_rdata_a,
    input  reg_idx_t i_raddr_b,
    output word_t    o_rdata_b
);

    word_t r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_mem[i] <= '0;
        end else if (i_we && i_waddr != ZERO_REG) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == ZERO_REG) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == ZERO_REG) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Register-read and operand-staging stage feeding the ALU through a single-entry output register.
module operand_fetch
    import minimips_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    of_req_if.slave  req,
    of_alu_if.master alu,
    input  logic     wb_en,
    input  reg_idx_t wb_addr,
    input  word_t    wb_data
);

    word_t    w_rf_rs;
    word_t    w_rf_rt;
    word_t    w_read_rs;
    word_t    w_read_rt;
    word_t    w_b_src;
    logic     w_accept;
    logic     w_wb_live;

    logic     r_out_valid;
    word_t    r_alu_a;
    word_t    r_alu_b;
    reg_idx_t r_held_rs;
    reg_idx_t r_held_rt;
    logic     r_held_imm;

    reg_file_32x32 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (req.rs),
        .o_rdata_a (w_rf_rs),
        .i_raddr_b (req.rt),
        .o_rdata_b (w_rf_rt)
    );

    assign w_wb_live = wb_en && (wb_addr != ZERO_REG);

    always_comb begin
        w_read_rs = w_rf_rs;
        if (req.rs == ZERO_REG)
            w_read_rs = '0;
        else if (wb_en && wb_addr == req.rs)
            w_read_rs = wb_data;

        w_read_rt = w_rf_rt;
        if (req.rt == ZERO_REG)
            w_read_rt = '0;
        else if (wb_en && wb_addr == req.rt)
            w_read_rt = wb_data;

        w_b_src = req.use_imm ? ext_imm(req.imm, req.sign_ext) : w_read_rt;
    end

    assign req.in_ready = !r_out_valid || alu.out_ready;
    assign w_accept     = req.in_valid && req.in_ready;

    // A held pair tracks write-backs to its source registers so it cannot go stale while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_held_rs   <= '0;
            r_held_rt   <= '0;
            r_held_imm  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_a     <= w_read_rs;
            r_alu_b     <= w_b_src;
            r_held_rs   <= req.rs;
            r_held_rt   <= req.rt;
            r_held_imm  <= req.use_imm;
        end else if (r_out_valid) begin
            if (alu.out_ready)
                r_out_valid <= 1'b0;
            if (w_wb_live && wb_addr == r_held_rs)
                r_alu_a <= wb_data;
            if (w_wb_live && !r_held_imm && wb_addr == r_held_rt)
                r_alu_b <= wb_data;
        end
    end

    assign alu.out_valid = r_out_valid;
    assign alu.alu_a     = r_alu_a;
    assign alu.alu_b     = r_alu_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with hand-computed expected values.
module tb_operand_fetch;
    import minimips_pkg::*;

    logic     clk;
    logic     rst_n;
    logic     wb_en;
    reg_idx_t wb_addr;
    word_t    wb_data;

    int n_vec;
    int n_err;

    of_req_if req ();
    of_alu_if alu ();

    operand_fetch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .alu     (alu),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input reg_idx_t s, input reg_idx_t t,
                         input imm_t im, input logic ui, input logic se);
        req.in_valid = v;
        req.rs       = s;
        req.rt       = t;
        req.imm      = im;
        req.use_imm  = ui;
        req.sign_ext = se;
    endtask

    task automatic wb(input logic en, input reg_idx_t a, input word_t d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        alu.out_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        #12;
        chk("rst_valid", {31'b0, alu.out_valid}, 32'd0);
        chk("rst_ready", {31'b0, req.in_ready}, 32'd1);
        chk("rst_a", alu.alu_a, 32'h0);
        chk("rst_b", alu.alu_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read through the register file
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        alu.out_ready = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("basic_valid", {31'b0, alu.out_valid}, 32'd1);
        chk("basic_a", alu.alu_a, 32'hDEADBEEF);
        chk("basic_b", alu.alu_b, 32'h0);

        // Same-cycle write-back bypass on both ports
        wb(1'b1, 5'd7, 32'h12345678);
        drive(1'b1, 5'd7, 5'd7, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("byp_a", alu.alu_a, 32'h12345678);
        chk("byp_b", alu.alu_b, 32'h12345678);

        // r0 write dropped; r7 now from storage
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive(1'b1, 5'd0, 5'd7, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("r0_a", alu.alu_a, 32'h0);
        chk("rf7_b", alu.alu_b, 32'h12345678);

        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd5, 5'd7, 16'h8001, 1'b1, 1'b1);
        tick();
        chk("sext_a", alu.alu_a, 32'hDEADBEEF);
        chk("sext_b", alu.alu_b, 32'hFFFF8001);

        drive(1'b1, 5'd5, 5'd7, 16'h8001, 1'b1, 1'b0);
        tick();
        chk("zext_b", alu.alu_b, 32'h00008001);

        // Drain with no new request: operands retained
        drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("drain_valid", {31'b0, alu.out_valid}, 32'd0);
        chk("drain_keep_b", alu.alu_b, 32'h00008001);

        // Stall and hold refresh
        wb(1'b1, 5'd4, 32'h00000044);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        alu.out_ready = 1'b0;
        drive(1'b1, 5'd3, 5'd4, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("stall_valid", {31'b0, alu.out_valid}, 32'd1);
        chk("stall_a", alu.alu_a, 32'h0);
        chk("stall_b", alu.alu_b, 32'h00000044);
        chk("stall_ready", {31'b0, req.in_ready}, 32'd0);

        wb(1'b1, 5'd3, 32'h00000055);
        drive(1'b1, 5'd9, 5'd9, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("refr_a", alu.alu_a, 32'h00000055);
        chk("refr_b_keep", alu.alu_b, 32'h00000044);
        chk("refr_ready", {31'b0, req.in_ready}, 32'd0);
        chk("refr_valid", {31'b0, alu.out_valid}, 32'd1);

        wb(1'b1, 5'd4, 32'h00000066);
        tick();
        chk("refr2_a", alu.alu_a, 32'h00000055);
        chk("refr2_b", alu.alu_b, 32'h00000066);

        // Asynchronous reset mid-stall
        wb(1'b0, 5'd0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, alu.out_valid}, 32'd0);
        chk("arst_a", alu.alu_a, 32'h0);
        chk("arst_b", alu.alu_b, 32'h0);
        drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        alu.out_ready = 1'b1;
        drive(1'b1, 5'd9, 5'd5, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("post_rst_a", alu.alu_a, 32'h0);
        chk("post_rst_b", alu.alu_b, 32'h0);

        // Back-to-back throughput
        drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            wb(1'b1, reg_idx_t'(i), word_t'(32'h11 * i));
            tick();
        end
        wb(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, reg_idx_t'(i), 5'd0, imm_t'(i), 1'b1, 1'b0);
            tick();
            chk("b2b_valid", {31'b0, alu.out_valid}, 32'd1);
            chk("b2b_ready", {31'b0, req.in_ready}, 32'd1);
            chk("b2b_a", alu.alu_a, 32'h11 * i);
            chk("b2b_b", alu.alu_b, i);
        end
        drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("b2b_end", {31'b0, alu.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
